// File: rtl/axi4_slave_mem_bfm.sv
// Single-ID AXI4 slave with an internal 32-bit word memory and independent read/write channels.
// Optional macro AXI_SLV_BFM_WAIT_EN inserts WAIT_CYCLES idle cycles after W beats and around R beats.
module axi4_slave_mem_bfm #(
    parameter int unsigned MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
`ifdef AXI_SLV_BFM_WAIT_EN
    ,
    parameter int unsigned WAIT_CYCLES = 2
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int unsigned DEPTH   = 2 ** MEM_AW;
    localparam logic [32:0] DEPTH_W = 33'(1) << MEM_AW;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    function automatic logic addr_in_range(input logic [31:0] addr);
        return {1'b0, (addr - BASE_ADDR) >> 2} < DEPTH_W;
    endfunction

    function automatic logic [MEM_AW-1:0] word_index(input logic [31:0] addr);
        return MEM_AW'((addr - BASE_ADDR) >> 2);
    endfunction

    // For the legal WRAP lengths, (len+1)*4-1 is simply {len, 2'b11}.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [31:0] mask;
        mask = {22'd0, len, 2'b11};
        if (burst == BURST_FIXED) begin
            return addr;
        end
        if (burst == BURST_WRAP &&
            (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            return (addr & ~mask) | ((addr + 32'd4) & mask);
        end
        return addr + 32'd4;
    endfunction

    // ------------------------------------------------------------------
    // Shared handshake and control signals
    // ------------------------------------------------------------------
    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [31:0]       awaddr_q, awaddr_d;
    logic [7:0]        awlen_q, awlen_d;
    logic [1:0]        awburst_q, awburst_d;
    logic [7:0]        wbeat_q, wbeat_d;
    logic [1:0]        wresp_q, wresp_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [1:0]        arburst_q, arburst_d;
    logic [7:0]        rbeat_q, rbeat_d;
    logic              rd_decerr_q, rd_decerr_d;

    logic              aw_ready, w_ready, ar_ready, r_valid;
    logic              aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic              w_last_beat, r_last_beat, w_in_range;
    logic [1:0]        w_beat_resp;
    logic              w_stall, r_stall;
    logic              rd_en;
    logic [31:0]       rd_addr, r_addr_adv;
    logic [MEM_AW-1:0] wr_idx, rd_idx;
    logic [31:0]       rdata_raw;

    assign aw_ready = (w_state_q == W_IDLE);
    assign w_ready  = (w_state_q == W_DATA) && !w_stall;
    assign ar_ready = (r_state_q == R_IDLE);
    assign r_valid  = (r_state_q == R_DATA) && !r_stall;

    assign aw_fire  = S_AXI_AWVALID && aw_ready;
    assign w_fire   = S_AXI_WVALID && w_ready;
    assign b_fire   = S_AXI_BREADY && (w_state_q == W_RESP);
    assign ar_fire  = S_AXI_ARVALID && ar_ready;
    assign r_fire   = S_AXI_RREADY && r_valid;

`ifdef AXI_SLV_BFM_WAIT_EN
    logic [15:0] w_wait_q, w_wait_d, r_wait_q, r_wait_d;

    always_comb begin
        w_wait_d = w_wait_q;
        r_wait_d = r_wait_q;
        if (w_fire) begin
            w_wait_d = 16'(WAIT_CYCLES);
        end else if (w_wait_q != 16'd0) begin
            w_wait_d = w_wait_q - 16'd1;
        end
        // rd_en marks both the AR handshake and every non-final R handshake
        if (rd_en) begin
            r_wait_d = 16'(WAIT_CYCLES);
        end else if (r_wait_q != 16'd0) begin
            r_wait_d = r_wait_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_wait_q <= 16'd0;
            r_wait_q <= 16'd0;
        end else begin
            w_wait_q <= w_wait_d;
            r_wait_q <= r_wait_d;
        end
    end

    assign w_stall = (w_wait_q != 16'd0);
    assign r_stall = (r_wait_q != 16'd0);
`else
    assign w_stall = 1'b0;
    assign r_stall = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_fire) w_state_d = W_DATA;
            W_DATA:  if (w_fire && w_last_beat) w_state_d = W_RESP;
            W_RESP:  if (b_fire) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = aw_ready;
        S_AXI_WREADY  = w_ready;
        S_AXI_BVALID  = (w_state_q == W_RESP);
        S_AXI_BRESP   = (w_state_q == W_RESP) ? wresp_q : RESP_OKAY;
    end

    assign w_last_beat = (wbeat_q == awlen_q);
    assign w_in_range  = addr_in_range(awaddr_q);

    // DECERR outranks a WLAST mismatch on the same beat
    always_comb begin
        w_beat_resp = RESP_OKAY;
        if (!w_in_range) begin
            w_beat_resp = RESP_DECERR;
        end else if (S_AXI_WLAST != w_last_beat) begin
            w_beat_resp = RESP_SLVERR;
        end
    end

    always_comb begin
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awburst_d = awburst_q;
        wbeat_d   = wbeat_q;
        wresp_d   = wresp_q;
        if (aw_fire) begin
            awaddr_d  = S_AXI_AWADDR;
            awlen_d   = S_AXI_AWLEN;
            awburst_d = S_AXI_AWBURST;
            wbeat_d   = 8'd0;
            wresp_d   = RESP_OKAY;
        end else if (w_fire) begin
            awaddr_d = next_addr(awaddr_q, awlen_q, awburst_q);
            wbeat_d  = wbeat_q + 8'd1;
            // Encodings order OKAY < SLVERR < DECERR, so "worst" is the maximum
            if (w_beat_resp > wresp_q) begin
                wresp_d = w_beat_resp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr_q  <= 32'd0;
            awlen_q   <= 8'd0;
            awburst_q <= 2'd0;
            wbeat_q   <= 8'd0;
            wresp_q   <= RESP_OKAY;
        end else begin
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awburst_q <= awburst_d;
            wbeat_q   <= wbeat_d;
            wresp_q   <= wresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_fire) r_state_d = R_DATA;
            R_DATA:  if (r_fire && r_last_beat) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = ar_ready;
        S_AXI_RVALID  = r_valid;
        S_AXI_RLAST   = r_valid && r_last_beat;
        S_AXI_RRESP   = (r_valid && rd_decerr_q) ? RESP_DECERR : RESP_OKAY;
        S_AXI_RDATA   = (r_valid && !rd_decerr_q) ? rdata_raw : 32'h0;
    end

    assign r_last_beat = (rbeat_q == arlen_q);
    assign r_addr_adv  = next_addr(araddr_q, arlen_q, arburst_q);

    // The memory is read on the handshake that starts a beat, so RDATA stays put while stalled
    assign rd_en   = ar_fire || (r_fire && !r_last_beat);
    assign rd_addr = ar_fire ? S_AXI_ARADDR : r_addr_adv;

    always_comb begin
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arburst_d   = arburst_q;
        rbeat_d     = rbeat_q;
        rd_decerr_d = rd_decerr_q;
        if (ar_fire) begin
            araddr_d  = S_AXI_ARADDR;
            arlen_d   = S_AXI_ARLEN;
            arburst_d = S_AXI_ARBURST;
            rbeat_d   = 8'd0;
        end else if (r_fire && !r_last_beat) begin
            araddr_d = r_addr_adv;
            rbeat_d  = rbeat_q + 8'd1;
        end
        if (rd_en) begin
            rd_decerr_d = !addr_in_range(rd_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            araddr_q    <= 32'd0;
            arlen_q     <= 8'd0;
            arburst_q   <= 2'd0;
            rbeat_q     <= 8'd0;
            rd_decerr_q <= 1'b0;
        end else begin
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arburst_q   <= arburst_d;
            rbeat_q     <= rbeat_d;
            rd_decerr_q <= rd_decerr_d;
        end
    end

    // ------------------------------------------------------------------
    // Byte-lane memories; same-cycle read of a word being written sees the old value
    // ------------------------------------------------------------------
    assign wr_idx = word_index(awaddr_q);
    assign rd_idx = word_index(rd_addr);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];
            logic [7:0] rdata_q;

            always_ff @(posedge clk) begin
                if (!rst && w_fire && w_in_range && S_AXI_WSTRB[gi]) begin
                    mem_q[wr_idx] <= S_AXI_WDATA[gi*8 +: 8];
                end
                if (rd_en) begin
                    rdata_q <= mem_q[rd_idx];
                end
            end

            assign rdata_raw[gi*8 +: 8] = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_axi4_slave_mem_bfm.sv
// Randomized self-checking bench for axi4_slave_mem_bfm against a word-array reference model.
module tb_axi4_slave_mem_bfm;

    localparam int          MEM_AW = 10;
    localparam int          DEPTH  = 1 << MEM_AW;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          TMO    = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] S_AXI_AWADDR = '0;
    logic [7:0]  S_AXI_AWLEN = '0;
    logic [1:0]  S_AXI_AWBURST = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WLAST = 1'b0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic [7:0]  S_AXI_ARLEN = '0;
    logic [1:0]  S_AXI_ARBURST = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;

    always #5 clk = ~clk;

    axi4_slave_mem_bfm #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl    [DEPTH];
    logic [31:0] wdat   [256];
    logic [3:0]  wstb   [256];
    logic [31:0] rd_got [256];
    logic [1:0]  last_bresp;
    int          wrap_lens [4] = '{1, 3, 7, 15};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference address of beat i, from the burst rules directly
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input logic [1:0] burst, input int i);
        longint s, size, lower;
        s = start;
        if (burst == 2'd0) return start;
        if (burst == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            size  = (len + 1) * 4;
            lower = (s / size) * size;
            return 32'(lower + ((s - lower) + 4 * i) % size);
        end
        return start + 32'(4 * i);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // All tasks start and end one time unit after a rising edge
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input int last_pos, input bit gaps);
        logic [31:0] a;
        logic [1:0]  r, exp_resp;
        int          t;
        exp_resp = 2'd0;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, burst, i);
            if (in_rng(a)) begin
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) mdl[widx(a)][b*8 +: 8] = wdat[i][b*8 +: 8];
                r = ((i == last_pos) != (i == len)) ? 2'd2 : 2'd0;
            end else begin
                r = 2'd3;
            end
            if (r > exp_resp) exp_resp = r;
        end

        S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        t = 0;
        @(negedge clk);
        while (!S_AXI_AWREADY && t < TMO) begin @(negedge clk); t++; end
        check("aw_handshake", 32'(S_AXI_AWREADY), 32'd1);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;

        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                S_AXI_WVALID = 1'b0;
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            S_AXI_WDATA = wdat[i]; S_AXI_WSTRB = wstb[i];
            S_AXI_WLAST = (i == last_pos); S_AXI_WVALID = 1'b1;
            t = 0;
            @(negedge clk);
            while (!S_AXI_WREADY && t < TMO) begin @(negedge clk); t++; end
            check("w_handshake", 32'(S_AXI_WREADY), 32'd1);
            @(posedge clk); #1;
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;

        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        S_AXI_BREADY = 1'b1;
        t = 0;
        @(negedge clk);
        while (!S_AXI_BVALID && t < TMO) begin @(negedge clk); t++; end
        check("bvalid", 32'(S_AXI_BVALID), 32'd1);
        last_bresp = S_AXI_BRESP;
        check("bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b0;
        $display("WR addr=%h len=%0d burst=%0d last_pos=%0d bresp=%0d", addr, len, burst, last_pos, last_bresp);
    endtask

    // rmode: 0 = RREADY held high, 1 = toggling 1/0, 2 = random
    task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input int rmode);
        logic [31:0] a, ed;
        logic [1:0]  er;
        int          t, i, cyc;
        S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        t = 0;
        @(negedge clk);
        while (!S_AXI_ARREADY && t < TMO) begin @(negedge clk); t++; end
        check("ar_handshake", 32'(S_AXI_ARREADY), 32'd1);
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        check("r_first_latency", 32'(S_AXI_RVALID), 32'd1);
        i = 0; cyc = 0;
        while (i <= len && cyc < TMO * (len + 1)) begin
            if (S_AXI_RVALID) begin
                a = beat_addr(addr, len, burst, i);
                if (in_rng(a)) begin ed = mdl[widx(a)]; er = 2'd0; end
                else begin ed = 32'd0; er = 2'd3; end
                check("rdata", S_AXI_RDATA, ed);
                check("rresp", 32'(S_AXI_RRESP), 32'(er));
                check("rlast", 32'(S_AXI_RLAST), 32'(i == len));
                if (S_AXI_RREADY) begin rd_got[i] = S_AXI_RDATA; i++; end
            end
            @(posedge clk); #1;
            cyc++;
            if (rmode == 1)      S_AXI_RREADY = ~S_AXI_RREADY;
            else if (rmode == 2) S_AXI_RREADY = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("r_beats", 32'(i), 32'(len + 1));
        check("r_idle_after", 32'(S_AXI_RVALID), 32'd0);
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b0;
        $display("RD addr=%h len=%0d burst=%0d mode=%0d beats=%0d", addr, len, burst, rmode, i);
    endtask

    initial begin
        logic [1:0]  burst;
        logic [31:0] addr;
        int          len, last_pos;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd1);
        check("rst_wready",  32'(S_AXI_WREADY),  32'd0);
        check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("rst_rlast",   32'(S_AXI_RLAST),   32'd0);
        check("rst_rdata",   S_AXI_RDATA,        32'd0);
        @(posedge clk); #1;

        // Zero-fill so every word has a known value
        for (int i = 0; i < 256; i++) begin wdat[i] = 32'd0; wstb[i] = 4'hF; end
        for (int k = 0; k < 4; k++) axi_write(32'(k * 1024), 255, 2'd1, 255, 1'b0);

        wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
        axi_write(32'h10, 0, 2'd1, 0, 1'b0);
        check("single_bresp", 32'(last_bresp), 32'd0);
        axi_read(32'h10, 0, 2'd1, 0);
        check("single_rdata", rd_got[0], 32'hDEAD_BEEF);

        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
        axi_write(32'h100, 3, 2'd1, 3, 1'b0);
        axi_read(32'h100, 3, 2'd1, 0);
        for (int i = 0; i < 4; i++) check("incr_rdata", rd_got[i], 32'(i + 1));

        axi_read(32'h108, 3, 2'd2, 0);
        check("wrap_b0", rd_got[0], 32'd3);
        check("wrap_b1", rd_got[1], 32'd4);
        check("wrap_b2", rd_got[2], 32'd1);
        check("wrap_b3", rd_got[3], 32'd2);

        wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
        axi_write(32'h20, 0, 2'd1, 0, 1'b0);
        wdat[0] = 32'h0; wstb[0] = 4'h5;
        axi_write(32'h20, 0, 2'd1, 0, 1'b0);
        axi_read(32'h20, 0, 2'd1, 0);
        check("strobe_rdata", rd_got[0], 32'hFF00_FF00);

        wdat[0] = 32'h1234_5678; wstb[0] = 4'hF;
        axi_write(BASE + 32'(4 * DEPTH), 0, 2'd1, 0, 1'b0);
        check("decerr_bresp", 32'(last_bresp), 32'd3);
        axi_read(32'h0, 0, 2'd1, 0);
        check("decerr_unchanged", rd_got[0], 32'd0);
        axi_read(BASE + 32'(4 * DEPTH), 0, 2'd1, 0);

        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
        axi_write(32'h200, 3, 2'd1, 1, 1'b0);
        check("slverr_bresp", 32'(last_bresp), 32'd2);
        axi_read(32'h200, 3, 2'd1, 0);
        check("slverr_beat3", rd_got[3], 32'hA3);

        axi_read(32'h0FE0, 7, 2'd1, 1);

        // Reset in the middle of a stalled read burst
        S_AXI_ARADDR = 32'h100; S_AXI_ARLEN = 8'd7; S_AXI_ARBURST = 2'd1; S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        check("mid_rvalid", 32'(S_AXI_RVALID), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("post_rst_arready", 32'(S_AXI_ARREADY), 32'd1);
        S_AXI_RREADY = 1'b1;
        repeat (3) begin @(negedge clk); check("post_rst_no_r", 32'(S_AXI_RVALID), 32'd0); end
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b0;

        // Write and read channels running concurrently on disjoint regions
        for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(0, 15)); end
        fork
            axi_write(32'h800, 7, 2'd1, 7, 1'b1);
            axi_read(32'h100, 3, 2'd1, 2);
        join

        for (int n = 0; n < 60; n++) begin
            burst = 2'($urandom_range(0, 3));
            if (burst == 2'd2 && $urandom_range(0, 3) != 0) len = wrap_lens[$urandom_range(0, 3)];
            else len = $urandom_range(0, 15);
            addr = 32'($urandom_range(0, DEPTH + 15)) << 2;
            if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(0, 15)); end
                last_pos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : len;
                axi_write(addr, len, burst, last_pos, 1'b1);
            end else begin
                axi_read(addr, len, burst, $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_slave_mem_bfm.md
Name: axi4_slave_mem_bfm

Overview:
- Single-ID AXI4 responder with internal word memory; the memory-side counterpart of the AXI4 master BFM.
- Used in testbench tops as the slave endpoint, so master-side blocks can be run against a known-good memory.
- Write and read channels are independent and may run concurrently.
- Each channel accepts one burst at a time.

Parameters:
MEM_AW, 10, word-address width; memory depth = 2**MEM_AW 32-bit words
BASE_ADDR, 32'h0000_0000, byte address of memory word 0

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
S_AXI_AWADDR  in  32  write burst start byte address
S_AXI_AWLEN  in  8  beats minus 1
S_AXI_AWBURST  in  2  0 FIXED, 1 INCR, 2 WRAP
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  response valid
S_AXI_BREADY  in  1  response ready
S_AXI_ARADDR  in  32  read burst start byte address
S_AXI_ARLEN  in  8  beats minus 1
S_AXI_ARBURST  in  2  burst type, encoded as for AW
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset values: AWREADY=1, ARREADY=1; all other outputs 0. Both FSMs go to IDLE. Memory contents are kept.
- Reset during a burst abandons it; no B or R beat is issued after reset.
- All transfers are full-width (4 bytes). Address bits [1:0] are ignored.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. An AW handshake latches address, len and burst, drops AWREADY and moves to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB, then advances the address.
  - The beat on which the beat count equals len moves to W_RESP.
  - If WLAST does not match the final-beat position, the response is SLVERR. Burst length follows AWLEN regardless of WLAST.
  - W_RESP: BVALID=1 until BREADY, then W_IDLE with AWREADY=1 the next cycle.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. An AR handshake latches address, len and burst.
  - First RVALID is one cycle after the AR handshake.
  - RDATA, RRESP and RLAST are held stable while RVALID=1 and RREADY=0.
  - Each R handshake advances the address; the next beat follows back-to-back.
  - RLAST=1 on beat len. The handshake on that beat returns to R_IDLE.
- Address update rules:
  - FIXED: address does not change.
  - INCR: address += 4.
  - WRAP: address += 4 within a boundary of (len+1)*4 bytes. len must be 1, 3, 7 or 15; any other len is treated as INCR.
- Decode:
  - A word is in range if (addr - BASE_ADDR) >> 2 < 2**MEM_AW.
  - Out-of-range beats respond DECERR (2'b11); writes are dropped and reads return 0.
  - DECERR takes priority over SLVERR.
  - Responses are OKAY otherwise.
- Write response is the worst response seen in the burst.
- Read/write collision: a write and a read to the same word in the same cycle return the old data.

Optional Feature:
- Macro: AXI_SLV_BFM_WAIT_EN.
- Defined:
  - Adds parameter WAIT_CYCLES, default 2.
  - After each W handshake, WREADY is held 0 for WAIT_CYCLES cycles.
  - After each non-final R handshake, RVALID is held 0 for WAIT_CYCLES cycles.
  - The first RVALID is also delayed by WAIT_CYCLES cycles.
- Undefined: zero-wait behaviour as specified above.

Test Plan:
- Single write: AW 0x10, len 0, INCR; W 0xDEADBEEF, strb 0xF, last -> BRESP OKAY. Read of 0x10 -> RDATA 0xDEADBEEF, RLAST=1.
- INCR write burst: 0x100, len 3, data 1..4 -> readback len 3 returns 1, 2, 3, 4; RLAST only on beat 3.
- WRAP read burst: 0x108, len 3 -> words read in order 0x108, 0x10C, 0x100, 0x104.
- Byte strobe: write 0x20 with 0xFFFFFFFF, then write 0x00000000 with strb 0x5 -> readback 0xFF00FF00.
- Error paths:
  - Write at BASE_ADDR + 4*2**MEM_AW -> BRESP DECERR, memory unchanged.
  - WLAST on beat 1 of a len 3 burst -> 4 beats accepted, BRESP SLVERR.
- Backpressure: RREADY toggling 1/0 during a len 7 read -> 8 beats, RDATA stable while stalled. Reset asserted mid-burst -> RVALID=0 and ARREADY=1 the following cycle.
